// File: rtl/eth_tx_gen_pkg.sv
// Shared types and constants for the Ethernet TX test-frame generator.
// The SEQ state exists only when ETH_TX_FRAME_GEN_SEQ_EN is defined.
package eth_tx_gen_pkg;

`ifdef ETH_TX_FRAME_GEN_SEQ_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_SEQ     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;
`endif

  localparam int unsigned HDR_BYTES         = 32'd14;
  localparam int unsigned SEQ_BYTES         = 32'd4;
  localparam int unsigned DEF_MIN_FRAME_LEN = 32'd60;
  localparam int unsigned DEF_MAX_FRAME_LEN = 32'd1514;

  // Byte idx of the 14-byte header, byte 0 taken from bits [111:104].
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    return 8'(hdr >> (7'd104 - {idx, 3'b000}));
  endfunction

endpackage

// File: rtl/eth_tx_gen_gap_timer.sv
// 32-bit inter-frame gap down-counter; done is high while the count is at 1 or below.
module eth_tx_gen_gap_timer
  import eth_tx_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] count_r;
  logic [31:0] count_s;
  logic        done_r;

  // Next count: load wins, otherwise decrement towards zero.
  always_comb begin
    count_s = count_r;
    if (load) begin
      count_s = load_val;
    end else if (count_r != 32'd0) begin
      count_s = count_r - 32'd1;
    end else begin
      count_s = 32'd0;
    end
  end

  // Count and registered done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
      done_r  <= 1'b1;
    end else begin
      count_r <= count_s;
      done_r  <= (count_s <= 32'd1);
    end
  end

  assign done = done_r;

endmodule

// File: rtl/eth_tx_frame_gen.sv
// Continuous Ethernet test-frame source for an AXI-Stream MAC TX port.
// Define ETH_TX_FRAME_GEN_SEQ_EN to insert a 32-bit sequence number after the header.
module eth_tx_frame_gen
  import eth_tx_gen_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int unsigned MIN_FRAME_LEN = DEF_MIN_FRAME_LEN
) (
  input  logic         gtx_clk,
  input  logic         gtx_rst_n,
  input  logic         enable,
  input  logic [10:0]  frame_len,
  input  logic [31:0]  frame_gap,
  input  logic [111:0] header,
  output logic [7:0]   tx_axis_tdata,
  output logic         tx_axis_tvalid,
  output logic         tx_axis_tlast,
  output logic         tx_axis_tuser,
  input  logic         tx_axis_tready,
  output logic         busy,
  output logic [31:0]  frame_count
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] HDR_END = 11'(HDR_BYTES);
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
  localparam logic [10:0] PAY_START = 11'(HDR_BYTES + SEQ_BYTES);
`else
  localparam logic [10:0] PAY_START = 11'(HDR_BYTES);
`endif

  tx_state_e      state_r, state_s, nxt_region_s;
  logic [10:0]    idx_r, idx_s, nxt_idx_s;
  logic [10:0]    len_r, len_s;
  logic [31:0]    gap_r, gap_s;
  logic [111:0]   hdr_r, hdr_s;
  logic [7:0]     tdata_r, tdata_s, nxt_byte_s;
  logic           tvalid_r, tvalid_s;
  logic           tlast_r, tlast_s;
  logic           busy_r;
  logic [31:0]    frame_count_r, frame_count_s;
  logic           start_s, adv_s;
  logic           timer_load_s, timer_done_s;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
  logic [31:0]    seq_r, seq_s;
  logic [1:0]     seq_sel_s;
`endif

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    logic [10:0] res;
    if (len < MIN_LEN) begin
      res = MIN_LEN;
    end else if (len > MAX_LEN) begin
      res = MAX_LEN;
    end else begin
      res = len;
    end
    return res;
  endfunction

  eth_tx_gen_gap_timer u_gap_timer (
    .clk      (gtx_clk),
    .rst_n    (gtx_rst_n),
    .load     (timer_load_s),
    .load_val (gap_r),
    .done     (timer_done_s)
  );

  // Content and region of the byte that follows the one currently presented.
  always_comb begin
    nxt_idx_s    = idx_r + 11'd1;
    nxt_byte_s   = 8'h00;
    nxt_region_s = ST_PAYLOAD;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
    seq_sel_s    = 2'(nxt_idx_s - HDR_END);
`endif
    if (nxt_idx_s < HDR_END) begin
      nxt_byte_s   = hdr_byte(hdr_r, nxt_idx_s[3:0]);
      nxt_region_s = ST_HDR;
    end
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
    else if (nxt_idx_s < PAY_START) begin
      nxt_byte_s   = 8'(seq_r >> (5'd24 - {seq_sel_s, 3'b000}));
      nxt_region_s = ST_SEQ;
    end
`endif
    else begin
      nxt_byte_s   = 8'(nxt_idx_s - PAY_START);
      nxt_region_s = ST_PAYLOAD;
    end
  end

  // Frame sequencing: next state, output beat and per-frame counters.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    len_s         = len_r;
    gap_s         = gap_r;
    hdr_s         = hdr_r;
    tdata_s       = tdata_r;
    tvalid_s      = tvalid_r;
    tlast_s       = tlast_r;
    frame_count_s = frame_count_r;
    timer_load_s  = 1'b0;
    start_s       = 1'b0;
    adv_s         = 1'b0;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
    seq_s         = seq_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          start_s = 1'b1;
        end else begin
          tvalid_s = 1'b0;
          tlast_s  = 1'b0;
        end
      end
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
      ST_HDR, ST_SEQ, ST_PAYLOAD: begin
`else
      ST_HDR, ST_PAYLOAD: begin
`endif
        if (tvalid_r && tx_axis_tready) begin
          if (tlast_r) begin
            frame_count_s = frame_count_r + 32'd1;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
            seq_s         = seq_r + 32'd1;
`endif
            if (gap_r != 32'd0) begin
              state_s      = ST_GAP;
              timer_load_s = 1'b1;
              tvalid_s     = 1'b0;
              tlast_s      = 1'b0;
              tdata_s      = 8'h00;
            end else if (enable) begin
              start_s = 1'b1;
            end else begin
              state_s  = ST_IDLE;
              tvalid_s = 1'b0;
              tlast_s  = 1'b0;
              tdata_s  = 8'h00;
            end
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          tvalid_s = tvalid_r;
        end
      end
      ST_GAP: begin
        if (timer_done_s) begin
          if (enable) begin
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
        tdata_s  = 8'h00;
      end
    endcase

    // A start latches the new frame's parameters and presents header byte 0 at once.
    if (start_s) begin
      state_s  = ST_HDR;
      idx_s    = 11'd0;
      len_s    = clamp_len(frame_len);
      gap_s    = frame_gap;
      hdr_s    = header;
      tdata_s  = hdr_byte(header, 4'd0);
      tvalid_s = 1'b1;
      tlast_s  = 1'b0;
    end else if (adv_s) begin
      state_s  = nxt_region_s;
      idx_s    = nxt_idx_s;
      tdata_s  = nxt_byte_s;
      tvalid_s = 1'b1;
      tlast_s  = (nxt_idx_s == (len_r - 11'd1));
    end else begin
      idx_s = idx_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
    if (!gtx_rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= 11'd0;
      len_r         <= MIN_LEN;
      gap_r         <= 32'd0;
      hdr_r         <= 112'd0;
      tdata_r       <= 8'h00;
      tvalid_r      <= 1'b0;
      tlast_r       <= 1'b0;
      busy_r        <= 1'b0;
      frame_count_r <= 32'd0;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
      seq_r         <= 32'd0;
`endif
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      len_r         <= len_s;
      gap_r         <= gap_s;
      hdr_r         <= hdr_s;
      tdata_r       <= tdata_s;
      tvalid_r      <= tvalid_s;
      tlast_r       <= tlast_s;
      busy_r        <= (state_s != ST_IDLE);
      frame_count_r <= frame_count_s;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
      seq_r         <= seq_s;
`endif
    end
  end

  assign tx_axis_tdata  = tdata_r;
  assign tx_axis_tvalid = tvalid_r;
  assign tx_axis_tlast  = tlast_r;
  assign tx_axis_tuser  = 1'b0;
  assign busy           = busy_r;
  assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Scoreboard bench for eth_tx_frame_gen: a reference model queues expected beats and gaps,
// a negedge monitor compares every AXI-Stream transfer and stall against them.
module tb_eth_tx_frame_gen;

  localparam int LIMIT = 20000;
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
  localparam int PSTART = 18;
`else
  localparam int PSTART = 14;
`endif

  logic         gtx_clk = 1'b0;
  logic         gtx_rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [10:0]  frame_len = 11'd0;
  logic [31:0]  frame_gap = 32'd0;
  logic [111:0] header = 112'd0;
  logic [7:0]   tx_axis_tdata;
  logic         tx_axis_tvalid;
  logic         tx_axis_tlast;
  logic         tx_axis_tuser;
  logic         tx_axis_tready = 1'b0;
  logic         busy;
  logic [31:0]  frame_count;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  exp_q[$];
  int          gap_q[$];
  int          beat_idx = 0;
  int          frames_rx = 0;
  logic [31:0] seq_model = 32'd0;
  logic [31:0] fc_model = 32'd0;
  bit          rand_ready = 1'b0;

  eth_tx_frame_gen dut (
    .gtx_clk        (gtx_clk),
    .gtx_rst_n      (gtx_rst_n),
    .enable         (enable),
    .frame_len      (frame_len),
    .frame_gap      (frame_gap),
    .header         (header),
    .tx_axis_tdata  (tx_axis_tdata),
    .tx_axis_tvalid (tx_axis_tvalid),
    .tx_axis_tlast  (tx_axis_tlast),
    .tx_axis_tuser  (tx_axis_tuser),
    .tx_axis_tready (tx_axis_tready),
    .busy           (busy),
    .frame_count    (frame_count)
  );

  always #5 gtx_clk = ~gtx_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_budget(input string name, input int used);
    tests++;
    if (used >= LIMIT) begin
      fails++;
      $display("FAIL %s: timed out after %0d cycles", name, used);
    end
  endtask

  function automatic logic [111:0] rand_hdr();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[111:0];
  endfunction

  // Reference frame: header, optional sequence number, then 00,01,... up to the clamped length.
  task automatic push_frame(input logic [10:0] len_in, input logic [111:0] hdr);
    int n;
    n = (len_in < 11'd60) ? 60 : ((len_in > 11'd1514) ? 1514 : int'(len_in));
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      if (i < 14) b = 8'(hdr >> (8 * (13 - i)));
`ifdef ETH_TX_FRAME_GEN_SEQ_EN
      else if (i < 18) b = 8'(seq_model >> (8 * (17 - i)));
`endif
      else b = 8'((i - PSTART) % 256);
      exp_q.push_back({(i == n - 1), b});
    end
    seq_model = seq_model + 32'd1;
  endtask

  // Ready driver: always ready, or a fair coin per cycle.
  initial begin
    forever begin
      @(posedge gtx_clk);
      #1;
      tx_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares transfers, stall stability and inter-frame gaps.
  initial begin
    logic [7:0] pd;
    logic       pl;
    logic [8:0] e;
    bit         pstall;
    bit         pend;
    int         idle;
    pstall = 1'b0; pend = 1'b0; idle = 0; pd = 8'h00; pl = 1'b0;
    forever begin
      @(negedge gtx_clk);
      if (!gtx_rst_n) begin
        pstall = 1'b0; pend = 1'b0; beat_idx = 0;
      end else begin
        if (pstall) begin
          check("hold_tvalid", tx_axis_tvalid, 1'b1);
          check("hold_tdata", tx_axis_tdata, pd);
          check("hold_tlast", tx_axis_tlast, pl);
        end
        if (tx_axis_tvalid) begin
          if (pend) begin
            if (gap_q.size() != 0) check("gap_cycles", idle, gap_q.pop_front());
            pend = 1'b0;
          end
          if (tx_axis_tready) begin
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL extra_beat: got tdata %0h, expected no beat", tx_axis_tdata);
            end else begin
              e = exp_q.pop_front();
              check("tdata", tx_axis_tdata, e[7:0]);
              check("tlast", tx_axis_tlast, e[8]);
            end
            beat_idx++;
            if (tx_axis_tlast) begin
              frames_rx++; beat_idx = 0; pend = 1'b1; idle = 0;
            end
          end
          pstall = !tx_axis_tready; pd = tx_axis_tdata; pl = tx_axis_tlast;
        end else begin
          pstall = 1'b0;
          if (pend) begin
            if (busy) idle++;
            else pend = 1'b0;
          end
        end
      end
    end
  end

  // n frames; optional mid-frame parameter change after frame 1 starts; enable drops in frame n.
  task automatic run_phase(input int n, input logic [10:0] l0, input logic [31:0] g0,
                           input bit chg, input logic [10:0] l1, input logic [31:0] g1,
                           input bit rr, input int drop_beat);
    logic [111:0] h0, h1;
    int base, budget;
    h0 = rand_hdr(); h1 = rand_hdr();
    base = frames_rx;
    rand_ready = rr;
    frame_len = l0; frame_gap = g0; header = h0;
    for (int k = 1; k <= n; k++) begin
      if (k == 1 || !chg) push_frame(l0, h0);
      else push_frame(l1, h1);
      if (k < n) gap_q.push_back((k == 1 || !chg) ? int'(g0) : int'(g1));
    end
    fc_model = fc_model + 32'(n);
    @(negedge gtx_clk);
    enable = 1'b1;
    if (chg) begin
      budget = 0;
      while (!(frames_rx == base && beat_idx >= 1) && budget < LIMIT) begin
        @(negedge gtx_clk); budget++;
      end
      check_budget("first_beat_wait", budget);
      frame_len = l1; frame_gap = g1; header = h1;
    end
    budget = 0;
    while (!(frames_rx == base + n - 1 && beat_idx >= drop_beat) && budget < LIMIT) begin
      @(negedge gtx_clk); budget++;
    end
    check_budget("drop_wait", budget);
    enable = 1'b0;
    budget = 0;
    while (!(frames_rx == base + n && !busy) && budget < LIMIT) begin
      @(negedge gtx_clk); budget++;
    end
    check_budget("idle_wait", budget);
    @(negedge gtx_clk);
    check("frame_count", frame_count, fc_model);
    check("beats_left", exp_q.size(), 0);
    check("idle_tvalid", tx_axis_tvalid, 1'b0);
    check("idle_busy", busy, 1'b0);
    gap_q.delete();
  endtask

  // Reset asserted mid-frame at beat 30.
  task automatic reset_mid();
    int budget;
    rand_ready = 1'b0;
    frame_len = 11'd100; frame_gap = 32'd0; header = rand_hdr();
    push_frame(11'd100, header);
    @(negedge gtx_clk);
    enable = 1'b1;
    budget = 0;
    while (beat_idx < 30 && budget < LIMIT) begin
      @(negedge gtx_clk); budget++;
    end
    check_budget("beat30_wait", budget);
    #1;
    gtx_rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_tvalid", tx_axis_tvalid, 1'b0);
    check("rst_tlast", tx_axis_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_count", frame_count, 32'd0);
    exp_q.delete(); gap_q.delete();
    seq_model = 32'd0; fc_model = 32'd0;
    @(negedge gtx_clk);
    @(negedge gtx_clk);
    gtx_rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge gtx_clk);
    check("reset_tvalid", tx_axis_tvalid, 1'b0);
    check("reset_tlast", tx_axis_tlast, 1'b0);
    check("reset_tdata", tx_axis_tdata, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_count", frame_count, 32'd0);
    check("tuser", tx_axis_tuser, 1'b0);
    gtx_rst_n = 1'b1;
    @(negedge gtx_clk);

    run_phase(3, 11'd60, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 1);
    reset_mid();
    run_phase(1, 11'd100, 32'd3, 1'b0, 11'd0, 32'd0, 1'b0, 20);
    run_phase(2, 11'd10, 32'd2, 1'b0, 11'd0, 32'd0, 1'b1, 1);
    run_phase(1, 11'd2000, 32'd0, 1'b0, 11'd0, 32'd0, 1'b1, 1);
    run_phase(3, 11'd64, 32'd5, 1'b0, 11'd0, 32'd0, 1'b0, 1);
    run_phase(2, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b1, 1);
    for (int r = 0; r < 3; r++) begin
      run_phase(3, 11'($urandom_range(0, 1600)), 32'($urandom_range(0, 6)), 1'b1,
                11'($urandom_range(0, 1600)), 32'($urandom_range(0, 6)), 1'b1,
                int'($urandom_range(1, 50)));
    end
    check("tuser_end", tx_axis_tuser, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
